// File: rtl/branch_target_buffer_pkg.sv
// Shared types, constants and index/tag helpers for the fetch-side branch predictor.
package branch_target_buffer_pkg;

    localparam int          PC_ALIGN_BITS = 2;
    localparam logic [31:0] RESET_PC      = 32'h0040_0000;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } pred_slot_t;

    localparam pred_slot_t SLOT_EMPTY = '{valid: 1'b0, pc: RESET_PC, taken: 1'b0, target: RESET_PC};

    // Callers narrow the 32-bit results to their own BTB geometry.
    function automatic logic [31:0] btb_idx(input logic [31:0] pc, input int unsigned btb_width);
        return (pc >> PC_ALIGN_BITS) & ((32'd1 << btb_width) - 32'd1);
    endfunction

    function automatic logic [31:0] btb_tag(input logic [31:0] pc, input int unsigned btb_width);
        return pc >> (PC_ALIGN_BITS + btb_width);
    endfunction

endpackage

// File: rtl/branch_target_buffer_btb_store.sv
// Direct-mapped BTB array: valid/tag/target per entry.
// Latency: async read, write visible the cycle after wr_en/inv_en.
// Backpressure: none; a write or invalidate is accepted every cycle.
module btb_store #(
    parameter int IDX_W = 6,
    parameter int TAG_W = 24
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_target,
    input  logic             wr_en,
    input  logic             inv_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [31:0]      wr_target
);
    localparam int DEPTH = 1 << IDX_W;

    logic [DEPTH-1:0] valid_q;
    logic [TAG_W-1:0] tag_mem [DEPTH];
    logic [31:0]      tgt_mem [DEPTH];

    assign rd_valid  = valid_q[rd_idx];
    assign rd_tag    = tag_mem[rd_idx];
    assign rd_target = tgt_mem[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end else if (inv_en) begin
            valid_q[wr_idx] <= 1'b0;
        end
    end

    // Payload needs no reset: it is qualified by valid_q.
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            tag_mem[wr_idx] <= wr_tag;
            tgt_mem[wr_idx] <= wr_target;
        end
    end

endmodule

// File: rtl/branch_target_buffer.sv
// Fetch-side BTB predictor: IF lookup, ID/EX prediction slots, EX resolution and BTB training.
// Latency: prediction combinational in IF; mispredict combinational when the instruction leaves EX.
// Backpressure: en low holds both slots; resolution only fires on the cycle EX advances.
module branch_target_buffer
    import branch_target_buffer_pkg::*;
#(
    parameter int BTB_WIDTH   = 6,
    parameter int INDEX_WIDTH = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    input  logic                   flush,
    input  logic [31:0]            f_pc,
    output logic [INDEX_WIDTH-1:0] bht_index,
    input  logic [1:0]             bht_state,
    output logic                   pred_taken,
    output logic [31:0]            pred_next_pc,
    input  logic                   ex_is_branch,
    input  logic                   ex_taken,
    input  logic [31:0]            ex_target,
    output logic                   mispredict,
    output logic [31:0]            redirect_pc
);
    localparam int TAG_WIDTH = 30 - BTB_WIDTH;

    pred_slot_t d_q, e_q;

    logic [BTB_WIDTH-1:0] f_idx, e_idx;
    logic [TAG_WIDTH-1:0] f_tag, e_tag;
    logic                 rd_valid;
    logic [TAG_WIDTH-1:0] rd_tag;
    logic [31:0]          rd_target;
    logic                 hit, resolve, wr_en, inv_en;
    logic [31:0]          f_pc_inc, e_pc_inc;
    logic                 unused_bht_lsb;

    assign unused_bht_lsb = bht_state[0];

    assign bht_index = f_pc[INDEX_WIDTH+1:2];
    assign f_idx     = BTB_WIDTH'(btb_idx(f_pc, BTB_WIDTH));
    assign f_tag     = TAG_WIDTH'(btb_tag(f_pc, BTB_WIDTH));
    assign e_idx     = BTB_WIDTH'(btb_idx(e_q.pc, BTB_WIDTH));
    assign e_tag     = TAG_WIDTH'(btb_tag(e_q.pc, BTB_WIDTH));
    assign f_pc_inc  = f_pc + 32'd4;
    assign e_pc_inc  = e_q.pc + 32'd4;

    btb_store #(
        .IDX_W(BTB_WIDTH),
        .TAG_W(TAG_WIDTH)
    ) u_store (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (f_idx),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_target (rd_target),
        .wr_en     (wr_en),
        .inv_en    (inv_en),
        .wr_idx    (e_idx),
        .wr_tag    (e_tag),
        .wr_target (ex_target)
    );

    assign hit          = rd_valid && (rd_tag == f_tag);
    assign pred_taken   = !rst && hit && bht_state[1];
    assign pred_next_pc = pred_taken ? rd_target : f_pc_inc;

    // A flushed EX instruction is dead: it neither redirects nor trains.
    assign resolve = e_q.valid && en && !flush && !rst;

    always_comb begin
        mispredict  = 1'b0;
        redirect_pc = 32'd0;
        wr_en       = 1'b0;
        inv_en      = 1'b0;
        if (resolve) begin
            if (ex_is_branch) begin
                mispredict = (e_q.taken != ex_taken) || (ex_taken && (e_q.target != ex_target));
                wr_en      = ex_taken;
            end else begin
                mispredict = e_q.taken;
                inv_en     = e_q.taken;
            end
            if (mispredict) begin
                redirect_pc = (ex_is_branch && ex_taken) ? ex_target : e_pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || mispredict || flush) begin
            d_q <= SLOT_EMPTY;
            e_q <= SLOT_EMPTY;
        end else if (en) begin
            d_q <= '{valid: 1'b1, pc: f_pc, taken: pred_taken, target: pred_next_pc};
            e_q <= d_q;
        end
    end

endmodule
